ask_symbol_scheduler: RTL and testbench
=======================================

// Module: ask_symbol_scheduler
// PURPOSE
// - Frame sequencer in front of the ASK mixer: takes a serial bit stream (valid/ready), groups bits into
//   1/2/3-bit symbols per mix mode, and emits one amplitude level per symbol slot at a constant bit rate.
// - Frame = PREAMBLE (alternating max/0 levels) -> PAYLOAD (frame_len symbols) -> GAP (silence) -> IDLE.
// - Drives the data_converter level/mode inputs; the DDS carrier runs freely and is gated by amp_en.
// PARAMETERS
// - CLK_PER_BIT   5000  clk cycles per bit slot (10 kbit/s at 50 MHz); symbol period = CLK_PER_BIT*bps
// - PREAMBLE_SYMS 8     preamble length in symbols (>=1)
// - GAP_SYMS      4     post-frame silence in symbols (>=1)
// - LEN_W         8     width of frame_len
// PORTS
// - clk        in   1      system clock (one clock domain)
// - rst        in   1      synchronous reset, active-high
// - mode_in    in   2      00 off, 01 2ASK (bps=1), 10 4ASK (bps=2), 11 8ASK (bps=3)
// - start      in   1      1-cycle request to send one frame
// - frame_len  in   LEN_W  payload length in symbols, sampled with start
// - bit_in     in   1      serial payload bit
// - bit_valid  in   1      bit_in valid
// - bit_ready  out  1      scheduler accepts bit_in this cycle (transfer = valid & ready)
// - sym_level  out  3      amplitude level, 0..2^bps-1, registered
// - sym_strobe out  1      1-cycle pulse on first cycle of every symbol slot
// - mode_out   out  2      mode latched at start (00 in IDLE)
// - amp_en     out  1      1 in PREAMBLE/PAYLOAD, else 0
// - busy       out  1      1 whenever state != IDLE
// - underrun   out  1      1-cycle pulse: payload symbol boundary with assembler not full
// - frame_done out  1      1-cycle pulse on GAP->IDLE
// BEHAVIOUR
// - Reset (any state, any cycle): state IDLE, all outputs 0, timers and assembler cleared; takes effect next edge.
// - IDLE: start=1 with mode_in!=00 and busy=0 -> latch mode/bps/frame_len; next cycle PREAMBLE sym 0,
//   sym_strobe=1. start with mode_in=00 ignored. start while busy ignored. mode_in changes while busy ignored.
// - Bit timer: slot counter 0..CLK_PER_BIT-1, bit index 0..bps-1; boundary when both wrap; strobe follows.
// - PREAMBLE: symbol k (0-based) level = (k even) ? 2^bps-1 : 0. After PREAMBLE_SYMS symbols -> PAYLOAD
//   (or GAP if frame_len=0).
// - Assembler: MSB-first shift reg + count (0..bps). bit_ready = busy & state!=GAP & count<bps &
//   (symbols loaded + (count>0)) < frame_len. Prefetch allowed during PREAMBLE.
// - PAYLOAD boundary: count==bps -> sym_level=assembled value, count:=0. count<bps -> sym_level=0,
//   underrun pulse, partial bits discarded; a bit transferred in that same cycle is kept as first bit of
//   next symbol. Either way the symbol counts toward frame_len (fixed frame timing).
// - After frame_len payload symbols -> GAP: sym_level=0, amp_en=0, bit_ready=0 for GAP_SYMS symbols,
//   then frame_done pulse, IDLE; a start in the frame_done cycle is accepted.
// - Levels always < 2^bps; bits above bps in sym_level are 0.
// STRUCTURE
// - Shared package ask_pkg: state encoding (IDLE/PREAMBLE/PAYLOAD/GAP), mode constants, bps(mode) function.
// - One sub-module: ask_bit_timer (slot/bit-index counter, boundary pulse, CLK_PER_BIT, bps input).
// - Top: FSM, symbol counter, assembler, output registers.
// TESTING (bench with CLK_PER_BIT=4, PREAMBLE_SYMS=2, GAP_SYMS=1)
// - 2ASK, frame_len=4, bits 1,0,1,1 always valid -> levels 1,0 | 1,0,1,1 | 0; strobes every 4 clk; frame_done once.
// - 8ASK, frame_len=2, bits 1,0,1,0,1,1 -> preamble 7,0; payload 5,3; strobe spacing 12 clk.
// - 4ASK, frame_len=3, bit_valid low for symbol 2 -> levels 2,?,0 with one underrun pulse; frame length unchanged.
// - start while busy, mode_in changed mid-frame, start with mode 00 -> no effect on running frame / stays IDLE.
// - rst=1 mid-PAYLOAD -> next cycle busy=0, sym_level=0, bit_ready=0; fresh start reproduces scenario 1.
// - frame_len=0, 4ASK -> preamble 3,0 then GAP; bit_ready never asserted; frame_done after 3 symbols.

Source files
------------

// File: rtl/ask_pkg.sv
// Shared definitions for the ASK symbol scheduler: FSM state encoding,
// mix-mode codes and the helpers that map a mode to bits-per-symbol and full-scale level.
package ask_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_GAP      = 2'd3
    } ask_state_t;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_2ASK = 2'b01;
    localparam logic [1:0] MODE_4ASK = 2'b10;
    localparam logic [1:0] MODE_8ASK = 2'b11;

    function automatic logic [1:0] bps_of(input logic [1:0] mode);
        case (mode)
            MODE_2ASK: return 2'd1;
            MODE_4ASK: return 2'd2;
            MODE_8ASK: return 2'd3;
            default:   return 2'd0;
        endcase
    endfunction

    // Full-scale level for a symbol width; doubles as the mask for assembled symbols.
    function automatic logic [2:0] level_max(input logic [1:0] bps);
        case (bps)
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            2'd3:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/ask_bit_timer.sv
// Symbol-slot timer: CLK_PER_BIT cycles per bit, bps bits per symbol.
// Both counters run down; boundary marks the last cycle of the current symbol slot.
module ask_bit_timer #(
    parameter int CLK_PER_BIT = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       run,
    input  logic [1:0] bps,
    output logic       boundary
);

    localparam int SLOT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [SLOT_W-1:0] SLOT_TC = SLOT_W'(CLK_PER_BIT - 1);

    logic [SLOT_W-1:0] slot_cnt;
    logic [1:0]        bit_idx;

    assign boundary = run && (slot_cnt == '0) && (bit_idx == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt <= '0;
            bit_idx  <= 2'd0;
        end else if (load) begin
            slot_cnt <= SLOT_TC;
            bit_idx  <= bps - 2'd1;
        end else if (run) begin
            if (slot_cnt == '0) begin
                slot_cnt <= SLOT_TC;
                bit_idx  <= (bit_idx == 2'd0) ? bps - 2'd1 : bit_idx - 2'd1;
            end else begin
                slot_cnt <= slot_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ask_symbol_scheduler.sv
// ASK frame sequencer: preamble, payload symbols assembled from a serial bit stream, gap.
// Emits one registered amplitude level per symbol slot for the data converter.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | waiting for start; outputs quiet, mode_out = 00
//   PREAMBLE | alternating full-scale / zero symbols, payload bits prefetched
//   PAYLOAD  | one assembled symbol per slot, underrun pulse if not ready
//   GAP      | silent slots after the frame, then frame_done and IDLE
module ask_symbol_scheduler
    import ask_pkg::*;
#(
    parameter int CLK_PER_BIT   = 5000,
    parameter int PREAMBLE_SYMS = 8,
    parameter int GAP_SYMS      = 4,
    parameter int LEN_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode_in,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [2:0]       sym_level,
    output logic             sym_strobe,
    output logic [1:0]       mode_out,
    output logic             amp_en,
    output logic             busy,
    output logic             underrun,
    output logic             frame_done
);

    localparam int PW    = $clog2(PREAMBLE_SYMS + 1);
    localparam int GW    = $clog2(GAP_SYMS + 1);
    localparam int CNT_W = (LEN_W > PW) ? ((LEN_W > GW) ? LEN_W : GW)
                                        : ((PW > GW) ? PW : GW);
    localparam logic [CNT_W-1:0] PRE_N = CNT_W'(PREAMBLE_SYMS);
    localparam logic [CNT_W-1:0] GAP_N = CNT_W'(GAP_SYMS);

    ask_state_t       state, state_d;
    logic [CNT_W-1:0] sym_cnt, sym_cnt_d;
    logic [CNT_W-1:0] len_ext;
    logic [1:0]       bps_q, bps_d, mode_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [2:0]       shreg, shreg_d, level_d;
    logic [1:0]       acnt, acnt_d;
    logic             strobe_d, amp_d, underrun_d, done_d;
    logic             timer_load, emit, boundary, xfer;

    assign len_ext = CNT_W'(len_q);
    assign busy    = (state != ST_IDLE);

    // The symbol being assembled is payload index sym_cnt (0 during preamble),
    // so incoming bits belong to this frame while that index is below frame_len.
    always_comb begin
        bit_ready = 1'b0;
        if (acnt < bps_q) begin
            if (state == ST_PREAMBLE)     bit_ready = (len_q != '0);
            else if (state == ST_PAYLOAD) bit_ready = (sym_cnt < len_ext);
        end
    end

    assign xfer = bit_valid && bit_ready;

    ask_bit_timer #(.CLK_PER_BIT(CLK_PER_BIT)) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .run      (busy),
        .bps      (bps_d),
        .boundary (boundary)
    );

    always_comb begin
        state_d    = state;
        sym_cnt_d  = sym_cnt;
        bps_d      = bps_q;
        mode_d     = mode_out;
        len_d      = len_q;
        shreg_d    = shreg;
        acnt_d     = acnt;
        level_d    = sym_level;
        amp_d      = amp_en;
        strobe_d   = 1'b0;
        underrun_d = 1'b0;
        done_d     = 1'b0;
        timer_load = 1'b0;
        emit       = 1'b0;

        if (xfer) begin
            shreg_d = {shreg[1:0], bit_in};
            acnt_d  = acnt + 2'd1;
        end

        case (state)
            ST_IDLE: begin
                level_d = 3'd0;
                amp_d   = 1'b0;
                if (start && (mode_in != MODE_OFF)) begin
                    state_d    = ST_PREAMBLE;
                    mode_d     = mode_in;
                    bps_d      = bps_of(mode_in);
                    len_d      = frame_len;
                    sym_cnt_d  = CNT_W'(1);
                    shreg_d    = 3'd0;
                    acnt_d     = 2'd0;
                    level_d    = level_max(bps_of(mode_in));
                    amp_d      = 1'b1;
                    strobe_d   = 1'b1;
                    timer_load = 1'b1;
                end
            end
            ST_PREAMBLE: begin
                if (boundary) begin
                    strobe_d = 1'b1;
                    if (sym_cnt < PRE_N) begin
                        level_d   = sym_cnt[0] ? 3'd0 : level_max(bps_q);
                        sym_cnt_d = sym_cnt + 1'b1;
                    end else if (len_q == '0) begin
                        state_d   = ST_GAP;
                        level_d   = 3'd0;
                        amp_d     = 1'b0;
                        sym_cnt_d = CNT_W'(1);
                    end else begin
                        state_d   = ST_PAYLOAD;
                        emit      = 1'b1;
                        sym_cnt_d = CNT_W'(1);
                    end
                end
            end
            ST_PAYLOAD: begin
                if (boundary) begin
                    strobe_d = 1'b1;
                    if (sym_cnt < len_ext) begin
                        emit      = 1'b1;
                        sym_cnt_d = sym_cnt + 1'b1;
                    end else begin
                        state_d   = ST_GAP;
                        level_d   = 3'd0;
                        amp_d     = 1'b0;
                        sym_cnt_d = CNT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (boundary) begin
                    if (sym_cnt < GAP_N) begin
                        strobe_d  = 1'b1;
                        sym_cnt_d = sym_cnt + 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        done_d    = 1'b1;
                        mode_d    = MODE_OFF;
                        sym_cnt_d = '0;
                        shreg_d   = 3'd0;
                        acnt_d    = 2'd0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A short symbol is dropped, but a bit arriving on the boundary starts the next one.
        if (emit) begin
            if (acnt == bps_q) begin
                level_d = shreg & level_max(bps_q);
                shreg_d = 3'd0;
                acnt_d  = 2'd0;
            end else begin
                level_d    = 3'd0;
                underrun_d = 1'b1;
                shreg_d    = xfer ? {2'b00, bit_in} : 3'd0;
                acnt_d     = xfer ? 2'd1 : 2'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sym_cnt    <= '0;
            bps_q      <= 2'd0;
            len_q      <= '0;
            shreg      <= 3'd0;
            acnt       <= 2'd0;
            sym_level  <= 3'd0;
            sym_strobe <= 1'b0;
            mode_out   <= MODE_OFF;
            amp_en     <= 1'b0;
            underrun   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            sym_cnt    <= sym_cnt_d;
            bps_q      <= bps_d;
            len_q      <= len_d;
            shreg      <= shreg_d;
            acnt       <= acnt_d;
            sym_level  <= level_d;
            sym_strobe <= strobe_d;
            mode_out   <= mode_d;
            amp_en     <= amp_d;
            underrun   <= underrun_d;
            frame_done <= done_d;
        end
    end

endmodule

// File: tb/tb_ask_symbol_scheduler.sv
// Directed bench for ask_symbol_scheduler with CLK_PER_BIT=4, PREAMBLE_SYMS=2, GAP_SYMS=1.
// Each strobe is logged with its cycle, level, amp_en and mode_out and compared to hand-derived tables.
module tb_ask_symbol_scheduler;

    localparam int CPB = 4;
    localparam int PS  = 2;
    localparam int GS  = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic [1:0] mode_in = 2'b00;
    logic [7:0] frame_len = 8'd0;
    logic       bit_ready, sym_strobe, amp_en, busy, underrun, frame_done;
    logic [2:0] sym_level;
    logic [1:0] mode_out;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int t0 = 0;
    int t_base = 0;
    int fidx = 0;
    int n_under = 0;
    int n_done = 0;
    int t_done = 0;
    bit ready_seen = 1'b0;
    bit fbits[$];
    int frel[$];
    int lv[$];
    int lt[$];
    int la[$];
    int lm[$];

    ask_symbol_scheduler #(
        .CLK_PER_BIT(CPB), .PREAMBLE_SYMS(PS), .GAP_SYMS(GS), .LEN_W(8)
    ) dut (
        .clk(clk), .rst(rst), .mode_in(mode_in), .start(start), .frame_len(frame_len),
        .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .sym_level(sym_level), .sym_strobe(sym_strobe), .mode_out(mode_out),
        .amp_en(amp_en), .busy(busy), .underrun(underrun), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Present the next queued bit once its release time (cycles after frame setup) has come.
    task automatic feed_update();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        if (fidx < fbits.size()) begin
            if ((cyc - t_base) >= frel[fidx]) begin
                bit_valid = 1'b1;
                bit_in    = fbits[fidx];
            end
        end
    endtask

    task automatic step();
        bit xfer;
        xfer = bit_valid && bit_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (xfer) fidx++;
        if (sym_strobe) begin
            lv.push_back(int'(sym_level));
            lt.push_back(cyc);
            la.push_back(int'(amp_en));
            lm.push_back(int'(mode_out));
        end
        if (underrun) n_under++;
        if (frame_done) begin
            n_done++;
            t_done = cyc;
        end
        if (bit_ready) ready_seen = 1'b1;
        feed_update();
    endtask

    task automatic begin_frame(input logic [1:0] m, input int len);
        lv.delete(); lt.delete(); la.delete(); lm.delete();
        n_under = 0; n_done = 0; t_done = 0; ready_seen = 1'b0;
        fidx = 0; t_base = cyc;
        feed_update();
        start = 1'b1; mode_in = m; frame_len = 8'(len);
        step();
        start = 1'b0; frame_len = 8'hFF;
        t0 = cyc;
    endtask

    task automatic run_until_done(input int budget);
        for (int i = 0; i < budget && n_done == 0; i++) step();
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_chk++;
        if ({busy, bit_ready, sym_strobe, amp_en, underrun, frame_done} === 6'b0 &&
            sym_level === 3'd0 && mode_out === 2'd0) n_pass++;
        else $display("FAIL reset_outputs got busy=%b rdy=%b stb=%b amp=%b und=%b done=%b lvl=%0d mode=%0d exp all 0",
                      busy, bit_ready, sym_strobe, amp_en, underrun, frame_done, sym_level, mode_out);
        rst = 1'b0;
        step();
    endtask

    task automatic test_2ask();
        int exp_lv[] = '{1, 0, 1, 0, 1, 1, 0};
        fbits = '{1, 0, 1, 1}; frel = '{0, 0, 0, 0};
        begin_frame(2'b01, 4);
        run_until_done(200);
        n_chk++;
        if (lv.size() == 7) n_pass++;
        else $display("FAIL 2ask_strobe_count got %0d exp 7", lv.size());
        for (int k = 0; k < 7; k++) begin
            n_chk++;
            if (k < lv.size() && lv[k] == exp_lv[k] && lt[k] == t0 + k * CPB && la[k] == ((k < 6) ? 1 : 0))
                n_pass++;
            else $display("FAIL 2ask_slot[%0d] got lvl=%0d t=%0d amp=%0d exp lvl=%0d t=%0d",
                          k, (k < lv.size()) ? lv[k] : -1, (k < lt.size()) ? lt[k] - t0 : -1,
                          (k < la.size()) ? la[k] : -1, exp_lv[k], k * CPB);
        end
        n_chk++;
        if (n_done == 1 && t_done - t0 == 7 * CPB && n_under == 0) n_pass++;
        else $display("FAIL 2ask_done got n=%0d t=%0d und=%0d exp n=1 t=%0d und=0",
                      n_done, t_done - t0, n_under, 7 * CPB);
    endtask

    task automatic test_8ask();
        int exp_lv[] = '{7, 0, 5, 3, 0};
        fbits = '{1, 0, 1, 0, 1, 1}; frel = '{0, 0, 0, 0, 0, 0};
        begin_frame(2'b11, 2);
        run_until_done(300);
        n_chk++;
        if (lv.size() == 5) n_pass++;
        else $display("FAIL 8ask_strobe_count got %0d exp 5", lv.size());
        for (int k = 0; k < 5; k++) begin
            n_chk++;
            if (k < lv.size() && lv[k] == exp_lv[k] && lt[k] == t0 + k * 3 * CPB && lm[k] == 3)
                n_pass++;
            else $display("FAIL 8ask_slot[%0d] got lvl=%0d t=%0d exp lvl=%0d t=%0d",
                          k, (k < lv.size()) ? lv[k] : -1, (k < lt.size()) ? lt[k] - t0 : -1,
                          exp_lv[k], k * 3 * CPB);
        end
        n_chk++;
        if (n_done == 1 && t_done - t0 == 5 * 3 * CPB) n_pass++;
        else $display("FAIL 8ask_done got n=%0d t=%0d exp n=1 t=%0d", n_done, t_done - t0, 15 * CPB);
    endtask

    // Bits for payload symbol 1 are withheld past its boundary; symbol 2 arrives late but in time.
    task automatic test_underrun();
        int exp_lv[] = '{3, 0, 2, 0, 3, 0};
        fbits = '{1, 0, 1, 1}; frel = '{0, 0, 26, 26};
        begin_frame(2'b10, 3);
        run_until_done(300);
        n_chk++;
        if (lv.size() == 6) n_pass++;
        else $display("FAIL underrun_strobe_count got %0d exp 6", lv.size());
        for (int k = 0; k < 6; k++) begin
            n_chk++;
            if (k < lv.size() && lv[k] == exp_lv[k] && lt[k] == t0 + k * 2 * CPB) n_pass++;
            else $display("FAIL underrun_slot[%0d] got lvl=%0d t=%0d exp lvl=%0d t=%0d",
                          k, (k < lv.size()) ? lv[k] : -1, (k < lt.size()) ? lt[k] - t0 : -1,
                          exp_lv[k], k * 2 * CPB);
        end
        n_chk++;
        if (n_under == 1 && n_done == 1 && t_done - t0 == 6 * 2 * CPB) n_pass++;
        else $display("FAIL underrun_pulse got und=%0d done=%0d t=%0d exp und=1 done=1 t=%0d",
                      n_under, n_done, t_done - t0, 12 * CPB);
    endtask

    task automatic test_ignore();
        int exp_lv[] = '{1, 0, 1, 0, 1, 1, 0};
        int bad;
        fbits = '{1, 0, 1, 1}; frel = '{0, 0, 0, 0};
        begin_frame(2'b01, 4);
        repeat (5) step();
        start = 1'b1; mode_in = 2'b11; frame_len = 8'd1;
        step();
        start = 1'b0; mode_in = 2'b10;
        run_until_done(200);
        bad = (lv.size() == 7) ? 0 : 1;
        for (int k = 0; k < lv.size() && k < 7; k++)
            if (lv[k] != exp_lv[k] || lt[k] != t0 + k * CPB || lm[k] != 1) bad++;
        n_chk++;
        if (bad == 0) n_pass++;
        else $display("FAIL ignore_busy_frame got %0d bad slots of %0d exp 0 bad of 7", bad, lv.size());
        n_chk++;
        if (n_done == 1 && mode_out === 2'b00) n_pass++;
        else $display("FAIL ignore_done got n=%0d mode=%0d exp n=1 mode=0", n_done, mode_out);
        lv.delete();
        start = 1'b1; mode_in = 2'b00; frame_len = 8'd3;
        step();
        start = 1'b0;
        repeat (10) step();
        n_chk++;
        if (busy === 1'b0 && lv.size() == 0 && amp_en === 1'b0) n_pass++;
        else $display("FAIL ignore_mode_off got busy=%b strobes=%0d amp=%b exp busy=0 strobes=0 amp=0",
                      busy, lv.size(), amp_en);
    endtask

    task automatic test_rst_mid();
        fbits = '{1, 0, 1, 1}; frel = '{0, 0, 0, 0};
        begin_frame(2'b01, 4);
        repeat (14) step();
        rst = 1'b1;
        step();
        n_chk++;
        if (busy === 1'b0 && sym_level === 3'd0 && bit_ready === 1'b0 && amp_en === 1'b0) n_pass++;
        else $display("FAIL rst_mid got busy=%b lvl=%0d rdy=%b amp=%b exp 0 0 0 0",
                      busy, sym_level, bit_ready, amp_en);
        rst = 1'b0;
        step();
        test_2ask();
    endtask

    task automatic test_zero_len();
        int exp_lv[] = '{3, 0, 0};
        fbits.delete(); frel.delete();
        begin_frame(2'b10, 0);
        run_until_done(200);
        n_chk++;
        if (lv.size() == 3 && lv[0] == exp_lv[0] && lv[1] == exp_lv[1] && lv[2] == exp_lv[2] && la[2] == 0)
            n_pass++;
        else $display("FAIL zero_len_levels got n=%0d first=%0d exp n=3 levels 3,0,0",
                      lv.size(), (lv.size() > 0) ? lv[0] : -1);
        n_chk++;
        if (!ready_seen && n_done == 1 && t_done - t0 == 3 * 2 * CPB) n_pass++;
        else $display("FAIL zero_len_done got ready_seen=%0d n=%0d t=%0d exp 0 1 %0d",
                      ready_seen, n_done, t_done - t0, 6 * CPB);
    endtask

    initial begin
        test_reset();
        test_2ask();
        test_8ask();
        test_underrun();
        test_ignore();
        test_rst_mid();
        test_zero_len();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
